// File: rtl/cpu_types_pkg.sv
// Shared cache types for the snoop responder: dcache address split, snoop FSM states, widths.
package cpu_types_pkg;

  localparam int unsigned SNP_TAG_W = 26;
  localparam int unsigned SNP_IDX_W = 3;

  typedef struct packed {
    logic [SNP_TAG_W-1:0] tag;
    logic [SNP_IDX_W-1:0] idx;
    logic                 blkoff;
    logic [1:0]           bytoff;
  } dcachef_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    RESP,
    SUPPLY0,
    SUPPLY1,
    UPDATE,
    DONE
  } snoopState_t;

endpackage

// File: rtl/snoop_responder_if.sv
// Coherence bus between the bus controller (master) and a cache snoop responder (slave).
interface snoop_responder_if;
  import cpu_types_pkg::*;

  logic        ccwait;
  logic        ccinv;
  dcachef_t    ccsnoopaddr;
  logic        dwait;
  logic        ccwrite;
  logic        cctrans;
  logic [31:0] snp_dstore;

  modport master (
    output ccwait, ccinv, ccsnoopaddr, dwait,
    input  ccwrite, cctrans, snp_dstore
  );

  modport slave (
    input  ccwait, ccinv, ccsnoopaddr, dwait,
    output ccwrite, cctrans, snp_dstore
  );

endinterface

// File: rtl/snoop_tag_match.sv
// Per-way tag compare with lowest-way priority; reports hit, winning way and its dirty bit.
module snoop_tag_match
  import cpu_types_pkg::*;
#(
  parameter  int unsigned WAYS  = 2,
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1
) (
  input  logic [WAYS-1:0]                tag_valid,
  input  logic [WAYS-1:0]                tag_dirty,
  input  logic [WAYS-1:0][SNP_TAG_W-1:0] tag_tag,
  input  logic [SNP_TAG_W-1:0]           snp_tag,
  output logic                           hit,
  output logic [WAY_W-1:0]               way,
  output logic                           dirty
);

  // Scan from the top way down so the lowest matching way is the last writer.
  always_comb begin
    hit   = 1'b0;
    way   = '0;
    dirty = 1'b0;
    for (int i = int'(WAYS) - 1; i >= 0; i--) begin
      if (tag_valid[i] && (tag_tag[i] == snp_tag)) begin
        hit   = 1'b1;
        way   = WAY_W'(i);
        dirty = tag_dirty[i];
      end
    end
  end

endmodule

// File: rtl/snoop_responder.sv
// Dcache snoop agent: looks up snooped blocks, supplies Modified data, downgrades/invalidates.
// Optional SNOOP_LINK_EN: clear the LL/SC link register on a matching invalidating snoop.
module snoop_responder
  import cpu_types_pkg::*;
#(
  parameter  int unsigned WAYS  = 2,
  parameter  int unsigned SETS  = 8,
  localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1,
  localparam int unsigned IDX_W = $clog2(SETS)
) (
  input  logic                           CLK,
  input  logic                           nRST,
  snoop_responder_if.slave               bus,
  input  logic [WAYS-1:0]                tag_valid,
  input  logic [WAYS-1:0]                tag_dirty,
  input  logic [WAYS-1:0][SNP_TAG_W-1:0] tag_tag,
  input  logic [31:0]                    dat_word,
  input  logic [31:0]                    link_addr,
  input  logic                           link_valid,
  output logic [IDX_W-1:0]               tag_idx,
  output logic [WAY_W-1:0]               dat_way,
  output logic                           dat_blk,
  output logic                           upd_en,
  output logic                           upd_valid,
  output logic                           upd_dirty,
  output logic                           snp_busy,
  output logic                           link_clr
);

  snoopState_t      state, next_state;
  dcachef_t         snp_addr;
  logic             snp_inv;
  logic             hit_q, dirty_q;
  logic [WAY_W-1:0] way_q;

  logic             m_hit, m_dirty;
  logic [WAY_W-1:0] m_way;
  logic             link_match;
  logic             ccwrite, cctrans;
  logic [31:0]      snp_dstore;

  snoop_tag_match #(.WAYS(WAYS)) u_match (
    .tag_valid (tag_valid),
    .tag_dirty (tag_dirty),
    .tag_tag   (tag_tag),
    .snp_tag   (snp_addr.tag),
    .hit       (m_hit),
    .way       (m_way),
    .dirty     (m_dirty)
  );

  assign tag_idx = IDX_W'(snp_addr.idx);

`ifdef SNOOP_LINK_EN
  assign link_match = snp_inv & link_valid & (link_addr[31:3] == snp_addr[31:3]);
`else
  logic unused_link;
  assign link_match  = 1'b0;
  assign unused_link = ^{link_valid, link_addr};
`endif

  logic unused_offs;
  assign unused_offs = ^{snp_addr.blkoff, snp_addr.bytoff};

  // State register plus the snoop request and lookup result latched for the rest of the snoop.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state    <= IDLE;
      snp_addr <= '0;
      snp_inv  <= 1'b0;
      hit_q    <= 1'b0;
      dirty_q  <= 1'b0;
      way_q    <= '0;
    end else begin
      state <= next_state;
      if ((state == IDLE) && bus.ccwait) begin
        snp_addr <= bus.ccsnoopaddr;
        snp_inv  <= bus.ccinv;
      end
      if (state == LOOKUP) begin
        hit_q   <= m_hit;
        dirty_q <= m_dirty;
        way_q   <= m_way;
      end
    end
  end

  // Next-state and Moore output decode; a dropped ccwait before UPDATE abandons the snoop.
  always_comb begin
    next_state = state;
    snp_busy   = 1'b0;
    ccwrite    = 1'b0;
    cctrans    = 1'b0;
    dat_way    = '0;
    dat_blk    = 1'b0;
    snp_dstore = '0;
    upd_en     = 1'b0;
    upd_valid  = 1'b0;
    upd_dirty  = 1'b0;
    link_clr   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.ccwait) next_state = LOOKUP;
      end
      LOOKUP: begin
        snp_busy   = 1'b1;
        next_state = bus.ccwait ? RESP : IDLE;
      end
      RESP: begin
        snp_busy = 1'b1;
        cctrans  = 1'b1;
        ccwrite  = hit_q & dirty_q;
        link_clr = link_match;
        if (!bus.ccwait)          next_state = IDLE;
        else if (hit_q && dirty_q) next_state = SUPPLY0;
        else if (hit_q)            next_state = UPDATE;
        else                       next_state = DONE;
      end
      SUPPLY0, SUPPLY1: begin
        snp_busy   = 1'b1;
        ccwrite    = 1'b1;
        dat_way    = way_q;
        dat_blk    = (state == SUPPLY1);
        snp_dstore = dat_word;
        if (!bus.ccwait)    next_state = IDLE;
        else if (!bus.dwait) next_state = (state == SUPPLY0) ? SUPPLY1 : UPDATE;
      end
      UPDATE: begin
        snp_busy   = 1'b1;
        upd_en     = 1'b1;
        dat_way    = way_q;
        upd_valid  = ~snp_inv;
        upd_dirty  = 1'b0;
        next_state = DONE;
      end
      DONE: begin
        if (!bus.ccwait) next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  assign bus.ccwrite    = ccwrite;
  assign bus.cctrans    = cctrans;
  assign bus.snp_dstore = snp_dstore;

endmodule

// File: tb/tb_snoop_responder.sv
// Scoreboard bench for snoop_responder: stimulus queues expected bus events, a monitor checks them.
module tb_snoop_responder;
  import cpu_types_pkg::*;

  localparam int unsigned WAYS = 2;
  localparam int unsigned SETS = 8;

`ifdef SNOOP_LINK_EN
  localparam logic LC_EXP = 1'b1;
`else
  localparam logic LC_EXP = 1'b0;
`endif

  logic CLK  = 1'b0;
  logic nRST = 1'b1;
  always #5 CLK = ~CLK;

  snoop_responder_if bus();

  logic [WAYS-1:0]                tag_valid, tag_dirty;
  logic [WAYS-1:0][SNP_TAG_W-1:0] tag_tag;
  logic [31:0]                    dat_word, link_addr;
  logic                           link_valid;
  logic [2:0]                     tag_idx;
  logic [0:0]                     dat_way;
  logic                           dat_blk, upd_en, upd_valid, upd_dirty, snp_busy, link_clr;

  snoop_responder #(.WAYS(WAYS), .SETS(SETS)) dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .bus        (bus),
    .tag_valid  (tag_valid),
    .tag_dirty  (tag_dirty),
    .tag_tag    (tag_tag),
    .dat_word   (dat_word),
    .link_addr  (link_addr),
    .link_valid (link_valid),
    .tag_idx    (tag_idx),
    .dat_way    (dat_way),
    .dat_blk    (dat_blk),
    .upd_en     (upd_en),
    .upd_valid  (upd_valid),
    .upd_dirty  (upd_dirty),
    .snp_busy   (snp_busy),
    .link_clr   (link_clr)
  );

  // Cache array model read by the DUT through tag_idx/dat_way/dat_blk.
  logic                 mv  [WAYS][SETS];
  logic                 md  [WAYS][SETS];
  logic [SNP_TAG_W-1:0] mt  [WAYS][SETS];
  logic [31:0]          mem [WAYS][SETS][2];

  always_comb begin
    for (int w = 0; w < int'(WAYS); w++) begin
      tag_valid[w] = mv[w][tag_idx];
      tag_dirty[w] = md[w][tag_idx];
      tag_tag[w]   = mt[w][tag_idx];
    end
    dat_word = mem[dat_way][tag_idx][dat_blk];
  end

  int cyc = 0;
  int t0  = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // kind: 0 = snoop response, 1 = accepted data beat, 2 = frame update
  typedef struct {
    int          kind;
    int          cyc;
    logic [31:0] d;
    logic        a;
    logic        b;
    int          way;
  } exp_t;
  exp_t q[$];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endfunction

  function automatic void push(input int k, input int c, input logic [31:0] d,
                               input logic a, input logic b, input int w);
    exp_t e;
    e.kind = k; e.cyc = c; e.d = d; e.a = a; e.b = b; e.way = w;
    q.push_back(e);
  endfunction

  function automatic void take(input int k);
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL spurious_event: got event kind %0d expected none (cycle %0d)", k, cyc);
      return;
    end
    e = q.pop_front();
    chk("event_kind", 32'(k), 32'(e.kind));
    chk("event_cycle", 32'(cyc - t0), 32'(e.cyc));
    case (k)
      0: begin
        chk("resp_ccwrite", 32'(bus.ccwrite), 32'(e.a));
        chk("resp_link_clr", 32'(link_clr), 32'(e.b));
      end
      1: begin
        chk("beat_data", bus.snp_dstore, e.d);
        chk("beat_blk", 32'(dat_blk), 32'(e.a));
        chk("beat_way", 32'(dat_way), 32'(e.way));
      end
      default: begin
        chk("upd_valid", 32'(upd_valid), 32'(e.a));
        chk("upd_dirty", 32'(upd_dirty), 32'(e.b));
        chk("upd_way", 32'(dat_way), 32'(e.way));
      end
    endcase
  endfunction

  // Monitor: sample on the falling edge, away from the DUT's active edge.
  always @(negedge CLK) begin
    if (nRST === 1'b1) begin
      if (bus.cctrans) take(0);
      if (upd_en) take(2);
      if (snp_busy && bus.ccwrite && !bus.cctrans) begin
        if (!bus.dwait) take(1);
        else if (q.size() > 0 && q[0].kind == 1) chk("stall_data", bus.snp_dstore, q[0].d);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic clear_arrays();
    for (int w = 0; w < int'(WAYS); w++)
      for (int s = 0; s < int'(SETS); s++) begin
        mv[w][s] = 1'b0; md[w][s] = 1'b0; mt[w][s] = '0;
        mem[w][s][0] = '0; mem[w][s][1] = '0;
      end
  endtask

  task automatic start(input logic [31:0] addr, input logic inv, input logic dw);
    t0              = cyc;
    bus.ccsnoopaddr = addr;
    bus.ccinv       = inv;
    bus.dwait       = dw;
    bus.ccwait      = 1'b1;
  endtask

  task automatic finish_snoop(input int hold);
    tick(hold);
    chk("done_busy", 32'(snp_busy), 32'd0);
    bus.ccwait = 1'b0;
    bus.dwait  = 1'b0;
    tick(2);
  endtask

  initial begin
    clear_arrays();
    bus.ccwait = 1'b0; bus.ccinv = 1'b0; bus.ccsnoopaddr = '0; bus.dwait = 1'b0;
    link_addr = '0; link_valid = 1'b0;
    #2 nRST = 1'b0;
    #10;
    chk("rst_busy", 32'(snp_busy), 32'd0);
    chk("rst_cctrans", 32'(bus.cctrans), 32'd0);
    chk("rst_ccwrite", 32'(bus.ccwrite), 32'd0);
    chk("rst_upd_en", 32'(upd_en), 32'd0);
    chk("rst_tag_idx", 32'(tag_idx), 32'd0);
    chk("rst_dstore", bus.snp_dstore, 32'd0);
    @(posedge CLK); #1 nRST = 1'b1;
    tick(2);

    // Miss on an empty cache
    push(0, 2, '0, 1'b0, 1'b0, 0);
    start(32'h0000_0040, 1'b0, 1'b0);
    finish_snoop(5);

    // Clean hit in way 1, downgrade to S; mid-snoop address change must be ignored
    clear_arrays();
    mv[1][0] = 1'b1; mt[1][0] = 26'h1;
    push(0, 2, '0, 1'b0, 1'b0, 0);
    push(2, 3, '0, 1'b1, 1'b0, 1);
    start(32'h0000_0040, 1'b0, 1'b0);
    tick(1);
    bus.ccsnoopaddr = 32'h0000_01C0;
    tick(1);
    chk("hit_tag_idx", 32'(tag_idx), 32'd0);
    finish_snoop(3);

    // Both ways match (way 0 clean, way 1 dirty): lowest way wins, invalidate
    clear_arrays();
    mv[0][5] = 1'b1; mt[0][5] = 26'hA; md[0][5] = 1'b0;
    mv[1][5] = 1'b1; mt[1][5] = 26'hA; md[1][5] = 1'b1;
    push(0, 2, '0, 1'b0, 1'b0, 0);
    push(2, 3, '0, 1'b0, 1'b0, 0);
    start(32'h0000_02A8, 1'b1, 1'b0);
    tick(2);
    chk("prio_tag_idx", 32'(tag_idx), 32'd5);
    finish_snoop(3);

    // Modified hit, invalidating, two stall cycles on word 0
    clear_arrays();
    mv[1][0] = 1'b1; mt[1][0] = 26'h2; md[1][0] = 1'b1;
    mem[1][0][0] = 32'hDEAD_BEEF; mem[1][0][1] = 32'hCAFE_F00D;
    push(0, 2, '0, 1'b1, 1'b0, 0);
    push(1, 5, 32'hDEAD_BEEF, 1'b0, 1'b0, 1);
    push(1, 6, 32'hCAFE_F00D, 1'b1, 1'b0, 1);
    push(2, 7, '0, 1'b0, 1'b0, 1);
    start(32'h0000_0080, 1'b1, 1'b1);
    tick(5);
    bus.dwait = 1'b0;
    finish_snoop(4);

    // Abort: ccwait drops while in SUPPLY1
    clear_arrays();
    mv[0][0] = 1'b1; mt[0][0] = 26'h2; md[0][0] = 1'b1;
    mem[0][0][0] = 32'h1111_1111; mem[0][0][1] = 32'h2222_2222;
    push(0, 2, '0, 1'b1, 1'b0, 0);
    push(1, 3, 32'h1111_1111, 1'b0, 1'b0, 0);
    start(32'h0000_0080, 1'b0, 1'b0);
    tick(4);
    bus.dwait  = 1'b1;
    bus.ccwait = 1'b0;
    tick(1);
    chk("abort_busy", 32'(snp_busy), 32'd0);
    chk("abort_ccwrite", 32'(bus.ccwrite), 32'd0);
    chk("abort_upd_en", 32'(upd_en), 32'd0);
    bus.dwait = 1'b0;
    tick(2);

    // Link register clear on invalidating snoop to the same doubleword, not on a read snoop
    clear_arrays();
    link_addr = 32'h0000_0084; link_valid = 1'b1;
    push(0, 2, '0, 1'b0, LC_EXP, 0);
    start(32'h0000_0080, 1'b1, 1'b0);
    finish_snoop(4);
    push(0, 2, '0, 1'b0, 1'b0, 0);
    start(32'h0000_0080, 1'b0, 1'b0);
    finish_snoop(4);
    link_valid = 1'b0;

    // Asynchronous reset while in SUPPLY0
    clear_arrays();
    mv[1][3] = 1'b1; mt[1][3] = 26'h2; md[1][3] = 1'b1;
    mem[1][3][0] = 32'hDEAD_BEEF; mem[1][3][1] = 32'hCAFE_F00D;
    push(0, 2, '0, 1'b1, 1'b0, 0);
    start(32'h0000_0098, 1'b0, 1'b1);
    tick(3);
    chk("supply0_data", bus.snp_dstore, 32'hDEAD_BEEF);
    nRST       = 1'b0;
    bus.ccwait = 1'b0;
    #1;
    chk("mrst_busy", 32'(snp_busy), 32'd0);
    chk("mrst_ccwrite", 32'(bus.ccwrite), 32'd0);
    chk("mrst_dstore", bus.snp_dstore, 32'd0);
    chk("mrst_tag_idx", 32'(tag_idx), 32'd0);
    chk("mrst_dat_way", 32'(dat_way), 32'd0);
    tick(2);
    nRST      = 1'b1;
    bus.dwait = 1'b0;
    tick(2);
    chk("post_rst_busy", 32'(snp_busy), 32'd0);
    chk("post_rst_cctrans", 32'(bus.cctrans), 32'd0);

    tick(3);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
